// File: rtl/rendering_pkg.sv
// Shared rendering constants and the plotter state encoding.
package rendering_pkg;

    localparam int unsigned SCREEN_W          = 320;
    localparam int unsigned SCREEN_H          = 240;
    localparam int unsigned X_W               = 9;
    localparam int unsigned Y_W               = 8;
    localparam int unsigned X_Y_PRODUCT_BITES = 17;
    localparam int unsigned ADDR_W            = X_Y_PRODUCT_BITES;
    localparam int unsigned COLOR_W           = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rect_plotter_span_stepper.sv
// Raster stepper: walks px/py across a clipped span and keeps the linear
// address in step by accumulation, so no per-pixel multiply is needed.
module span_stepper
    import rendering_pkg::*;
#(
    parameter int unsigned ROW_STRIDE = 320
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              advance_i,
    input  logic [X_W-1:0]    x0_i,
    input  logic [Y_W-1:0]    y0_i,
    input  logic [X_W:0]      x_end_i,
    input  logic [Y_W:0]      y_end_i,
    input  logic [ADDR_W-1:0] row_base_i,
    output logic [X_W-1:0]    px_o,
    output logic [Y_W-1:0]    py_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [X_W-1:0]    px_q, px_d, x0_q, x0_d;
    logic [Y_W-1:0]    py_q, py_d;
    logic [X_W:0]      x_end_q, x_end_d;
    logic [Y_W:0]      y_end_q, y_end_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, addr_q, addr_d;
    logic              x_wrap, y_last;

    assign x_wrap = ((X_W+1)'(px_q) + (X_W+1)'(1)) == x_end_q;
    assign y_last = ((Y_W+1)'(py_q) + (Y_W+1)'(1)) == y_end_q;
    assign last_o = x_wrap && y_last;

    always_comb begin
        px_d       = px_q;
        py_d       = py_q;
        x0_d       = x0_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        if (load_i) begin
            px_d       = x0_i;
            py_d       = y0_i;
            x0_d       = x0_i;
            x_end_d    = x_end_i;
            y_end_d    = y_end_i;
            row_base_d = row_base_i;
            addr_d     = row_base_i + ADDR_W'(x0_i);
        end else if (advance_i) begin
            if (x_wrap) begin
                // New row: the address restarts from the next row base plus the left edge.
                px_d       = x0_q;
                py_d       = py_q + Y_W'(1);
                row_base_d = row_base_q + ADDR_W'(ROW_STRIDE);
                addr_d     = row_base_q + ADDR_W'(ROW_STRIDE) + ADDR_W'(x0_q);
            end else begin
                px_d   = px_q + X_W'(1);
                addr_d = addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            px_q       <= '0;
            py_q       <= '0;
            x0_q       <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
        end else begin
            px_q       <= px_d;
            py_q       <= py_d;
            x0_q       <= x0_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
        end
    end

    assign px_o   = px_q;
    assign py_o   = py_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/rect_plotter.sv
// Rectangle fill engine: clips the request at start, then emits one pixel
// write per accepted valid/ready transfer in raster order.
module rect_plotter #(
    parameter int unsigned SCREEN_W = rendering_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = rendering_pkg::SCREEN_H,
    parameter int unsigned COLOR_W  = rendering_pkg::COLOR_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [rendering_pkg::X_W-1:0]          x0,
    input  logic [rendering_pkg::Y_W-1:0]          y0,
    input  logic [rendering_pkg::X_W-1:0]          w,
    input  logic [rendering_pkg::Y_W-1:0]          h,
    input  logic [COLOR_W-1:0]                     color,
    output logic                                   plot,
    input  logic                                   plot_ready,
    output logic [rendering_pkg::X_W-1:0]          px,
    output logic [rendering_pkg::Y_W-1:0]          py,
    output logic [rendering_pkg::ADDR_W-1:0]       addr,
    output logic [COLOR_W-1:0]                     pcolor,
    output logic                                   busy,
    output logic                                   done
);

    import rendering_pkg::*;

    localparam int unsigned XW = rendering_pkg::X_W;
    localparam int unsigned YW = rendering_pkg::Y_W;
    localparam int unsigned AW = rendering_pkg::ADDR_W;

    state_e             state_q;
    logic               plot_q, busy_q, done_q;
    logic [COLOR_W-1:0] pcolor_q;

    logic [XW:0]   x_sum, x_end_c;
    logic [YW:0]   y_sum, y_end_c;
    logic [AW-1:0] row_base_c;
    logic          empty, load, xfer, last;

    // Sums are one bit wider than the coordinates so the clip never wraps.
    assign x_sum      = (XW+1)'(x0) + (XW+1)'(w);
    assign y_sum      = (YW+1)'(y0) + (YW+1)'(h);
    assign x_end_c    = (32'(x_sum) > SCREEN_W) ? (XW+1)'(SCREEN_W) : x_sum;
    assign y_end_c    = (32'(y_sum) > SCREEN_H) ? (YW+1)'(SCREEN_H) : y_sum;
    assign empty      = (32'(x0) >= SCREEN_W) || (32'(y0) >= SCREEN_H) || (w == '0) || (h == '0);
    assign row_base_c = AW'(y0) * AW'(SCREEN_W);

    assign load = (state_q == IDLE) && start && !empty;
    assign xfer = plot_q && plot_ready;

    span_stepper #(
        .ROW_STRIDE (SCREEN_W)
    ) u_stepper (
        .clk        (clk),
        .reset      (reset),
        .load_i     (load),
        .advance_i  (xfer && !last),
        .x0_i       (x0),
        .y0_i       (y0),
        .x_end_i    (x_end_c),
        .y_end_i    (y_end_c),
        .row_base_i (row_base_c),
        .px_o       (px),
        .py_o       (py),
        .addr_o     (addr),
        .last_o     (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pcolor_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        pcolor_q <= color;
                        if (empty) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            plot_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer && last) begin
                        state_q <= DONE;
                        plot_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign pcolor = pcolor_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Randomised and directed checks of rect_plotter against a raster-loop reference.
module tb_rect_plotter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  x0 = '0;
    logic [7:0]  y0 = '0;
    logic [8:0]  w = '0;
    logic [7:0]  h = '0;
    logic [2:0]  color = '0;
    logic        plot;
    logic        plot_ready = 1'b0;
    logic [8:0]  px;
    logic [7:0]  py;
    logic [16:0] addr;
    logic [2:0]  pcolor;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int x;
        int y;
        int a;
    } pix_t;

    rect_plotter #(
        .SCREEN_W (320),
        .SCREEN_H (240),
        .COLOR_W  (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .color      (color),
        .plot       (plot),
        .plot_ready (plot_ready),
        .px         (px),
        .py         (py),
        .addr       (addr),
        .pcolor     (pcolor),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready.
    // poke: issue a stray start mid-run and during the done cycle.
    task automatic run_rect(input string name, input int x0v, input int y0v, input int wv,
                            input int hv, input int colv, input int mode, input bit poke);
        pix_t exp_q[$];
        pix_t e;
        int   xe, ye, n, cyc, k;
        bit   finished;
        xe = (x0v + wv > 320) ? 320 : x0v + wv;
        ye = (y0v + hv > 240) ? 240 : y0v + hv;
        for (int yy = y0v; yy < ye; yy++)
            for (int xx = x0v; xx < xe; xx++) begin
                e.x = xx; e.y = yy; e.a = yy * 320 + xx;
                exp_q.push_back(e);
            end
        n = exp_q.size();
        step();
        start = 1'b1; x0 = 9'(x0v); y0 = 8'(y0v); w = 9'(wv); h = 8'(hv); color = 3'(colv);
        plot_ready = 1'b0;
        step();
        start = 1'b0;
        color = ~color;
        cyc = 1;
        k = 0;
        finished = 1'b0;
        while (!finished && cyc < 4 * n + 20) begin
            if (exp_q.size() == 0) begin
                tests++;
                if (done !== 1'b1 || plot !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL %s done_pulse: got done=%b plot=%b busy=%b, expected 1 0 0", name, done, plot, busy);
                end
                if (mode == 0) begin
                    tests++;
                    if (cyc != n + 1) begin
                        fails++;
                        $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, cyc, n + 1);
                    end
                end
                if (poke) begin
                    start = 1'b1; x0 = 9'd0; y0 = 8'd0; w = 9'd4; h = 8'd4;
                end
                step();
                start = 1'b0;
                tests++;
                if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) begin
                    fails++;
                    $display("FAIL %s after_done: got done=%b plot=%b busy=%b, expected 0 0 0", name, done, plot, busy);
                end
                finished = 1'b1;
            end else begin
                case (mode)
                    0:       plot_ready = 1'b1;
                    1:       plot_ready = (k % 3) == 0;
                    default: plot_ready = $urandom_range(0, 1) == 1;
                endcase
                k++;
                e = exp_q[0];
                tests++;
                if (plot !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || int'(px) != e.x ||
                    int'(py) != e.y || int'(addr) != e.a || pcolor !== 3'(colv)) begin
                    fails++;
                    $display("FAIL %s pixel: got plot=%b busy=%b done=%b px=%0d py=%0d addr=%0d col=%0d, expected 1 1 0 px=%0d py=%0d addr=%0d col=%0d",
                             name, plot, busy, done, px, py, addr, pcolor, e.x, e.y, e.a, colv & 7);
                end
                if (poke && cyc == 2) begin
                    start = 1'b1; x0 = 9'd100; y0 = 8'd100; w = 9'd7; h = 8'd7;
                end
                if (plot === 1'b1 && plot_ready) void'(exp_q.pop_front());
                step();
                start = 1'b0;
                cyc++;
            end
        end
        if (!finished) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d pixels left after %0d cycles, expected 0", name, exp_q.size(), cyc);
        end
        plot_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || px !== '0 || py !== '0 ||
            addr !== '0 || pcolor !== '0) begin
            fails++;
            $display("FAIL reset_state: got plot=%b busy=%b done=%b px=%0d py=%0d addr=%0d col=%0d, expected all 0",
                     plot, busy, done, px, py, addr, pcolor);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_rect("basic", 10, 5, 3, 2, 5, 0, 1'b0);
    endtask

    task automatic test_stall();
        run_rect("stall", 10, 5, 3, 2, 6, 1, 1'b0);
    endtask

    task automatic test_clip();
        run_rect("clip", 318, 238, 5, 5, 3, 0, 1'b0);
    endtask

    task automatic test_empty();
        run_rect("empty_w0", 10, 5, 0, 2, 1, 0, 1'b0);
        run_rect("empty_x320", 320, 5, 3, 2, 1, 0, 1'b0);
        run_rect("empty_y240", 10, 240, 3, 2, 1, 0, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_rect("ignored_start", 10, 5, 3, 2, 2, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step();
        start = 1'b1; x0 = 9'd10; y0 = 8'd5; w = 9'd3; h = 8'd2; color = 3'd7;
        plot_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        plot_ready = 1'b0;
        tests++;
        if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || px !== '0 || py !== '0 ||
            addr !== '0 || pcolor !== '0) begin
            fails++;
            $display("FAIL reset_mid: got plot=%b busy=%b done=%b px=%0d py=%0d addr=%0d col=%0d, expected all 0",
                     plot, busy, done, px, py, addr, pcolor);
        end
        step();
        tests++;
        if (done !== 1'b0 || plot !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nodone: got done=%b plot=%b busy=%b, expected 0 0 0", done, plot, busy);
        end
        run_rect("after_reset", 10, 5, 3, 2, 4, 0, 1'b0);
    endtask

    task automatic test_random();
        int rx, ry;
        for (int i = 0; i < 10; i++) begin
            rx = (i % 2 == 0) ? $urandom_range(0, 300) : $urandom_range(300, 330);
            ry = (i % 3 == 0) ? $urandom_range(225, 245) : $urandom_range(0, 230);
            run_rect("random", rx, ry, $urandom_range(0, 24), $urandom_range(0, 8),
                     $urandom_range(0, 7), 2, 1'b0);
        end
    endtask

    task automatic test_full_screen();
        run_rect("full_screen", 0, 0, 320, 240, 6, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_clip();
        test_empty();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_full_screen();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
